mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM register.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_wb_reg.sv | 47 ++++
 rtl/mem_access_stage.sv | 150 +++++++++++++++
 tb/tb_mem_access_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// +--------------------------------------------------------------------------+
// | mem_pkg : shared defaults and FSM encoding for the MEM stage               |
// | Rev 1.0 : initial release                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

  localparam int DW_DEF      = 32;
  localparam int AW_DEF      = 5;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_wb_reg.sv
// +--------------------------------------------------------------------------+
// | mem_wb_reg : MEM/WB pipeline register; bubble clears the WB controls       |
// | Rev 1.0 : initial release                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_wb_reg
  import mem_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bubble,
  input  logic          mem_to_reg_in,
  input  logic          reg_write_in,
  input  logic [DW-1:0] read_data_in,
  input  logic [DW-1:0] alu_in,
  input  logic [AW-1:0] dest_in,
  output logic          mem_to_reg_out,
  output logic          reg_write_out,
  output logic [DW-1:0] read_data_out,
  output logic [DW-1:0] alu_out,
  output logic [AW-1:0] dest_out
);

  // Only the control bits need clearing for a bubble; data fields are don't-care in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_to_reg_out <= 1'b0;
      reg_write_out  <= 1'b0;
      read_data_out  <= '0;
      alu_out        <= '0;
      dest_out       <= '0;
    end else begin
      mem_to_reg_out <= mem_to_reg_in & ~bubble;
      reg_write_out  <= reg_write_in  & ~bubble;
      read_data_out  <= read_data_in;
      alu_out        <= alu_in;
      dest_out       <= dest_in;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// +--------------------------------------------------------------------------+
// | mem_access_stage : MEM stage, req/ack data-memory handshake with timeout   |
// | Option: MEM_ALIGN_CHECK_EN rejects word-misaligned accesses with bus_err   |
// | Rev 1.0 : initial release                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          BranchIN,
  input  logic          zeroIN,
  input  logic          MemReadIN,
  input  logic          MemWriteIN,
  input  logic          MemtoRegIN,
  input  logic          RegWriteIN,
  input  logic [DW-1:0] ALU_IN,
  input  logic [DW-1:0] readData2IN,
  input  logic [AW-1:0] DestinoIN,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic          PCSrc,
  output logic          stall,
  output logic          bus_err,
  output logic          MemtoRegOUT,
  output logic          RegWriteOUT,
  output logic [DW-1:0] readDataOUT,
  output logic [DW-1:0] ALU_OUT,
  output logic [AW-1:0] DestinoOUT
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          mem_op;
  logic          misalign;
  logic          req_c;
  logic          stall_c;
  logic          bubble;
  logic          err_nxt;

  assign mem_op = MemReadIN | MemWriteIN;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op & (ALU_IN[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    bubble    = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        count_nxt = '0;
        if (misalign) begin
          bubble  = 1'b1;
          err_nxt = 1'b1;
        end else if (mem_op) begin
          req_c = 1'b1;
          if (!dmem_ack) begin
            stall_c   = 1'b1;
            bubble    = 1'b1;
            state_nxt = ST_BUSY;
            count_nxt = CW'(1);
          end
        end
      end
      ST_BUSY: begin
        req_c = 1'b1;
        if (dmem_ack) begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end else if (count == CNT_LAST) begin
          // Stall drops here so upstream advances past the failed access.
          bubble    = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end else begin
          stall_c   = 1'b1;
          bubble    = 1'b1;
          count_nxt = (count == CNT_LAST) ? count : count + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      count   <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      bus_err <= err_nxt;
    end
  end

  // Gating with rst kills the request the instant reset asserts, even mid-access.
  assign dmem_req   = req_c & ~rst;
  assign stall      = stall_c & ~rst;
  assign dmem_we    = MemWriteIN;
  assign dmem_addr  = ALU_IN;
  assign dmem_wdata = readData2IN;
  assign PCSrc      = BranchIN & zeroIN & ~stall;

  mem_wb_reg #(
    .DW (DW),
    .AW (AW)
  ) u_mem_wb (
    .clk            (clk),
    .rst            (rst),
    .bubble         (bubble),
    .mem_to_reg_in  (MemtoRegIN),
    .reg_write_in   (RegWriteIN),
    .read_data_in   (dmem_rdata),
    .alu_in         (ALU_IN),
    .dest_in        (DestinoIN),
    .mem_to_reg_out (MemtoRegOUT),
    .reg_write_out  (RegWriteOUT),
    .read_data_out  (readDataOUT),
    .alu_out        (ALU_OUT),
    .dest_out       (DestinoOUT)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// +--------------------------------------------------------------------------+
// | tb_mem_access_stage : randomized self-checking bench for mem_access_stage  |
// | Rev 1.0 : initial release                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 16;

  localparam int K_ALU = 0;
  localparam int K_LW  = 1;
  localparam int K_SW  = 2;
  localparam int K_BR  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          BranchIN, zeroIN, MemReadIN, MemWriteIN, MemtoRegIN, RegWriteIN;
  logic [DW-1:0] ALU_IN, readData2IN, dmem_rdata;
  logic [AW-1:0] DestinoIN;
  logic          dmem_ack;
  logic          dmem_req, dmem_we, PCSrc, stall, bus_err, MemtoRegOUT, RegWriteOUT;
  logic [DW-1:0] dmem_addr, dmem_wdata, readDataOUT, ALU_OUT;
  logic [AW-1:0] DestinoOUT;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .BranchIN(BranchIN), .zeroIN(zeroIN), .MemReadIN(MemReadIN), .MemWriteIN(MemWriteIN),
    .MemtoRegIN(MemtoRegIN), .RegWriteIN(RegWriteIN), .ALU_IN(ALU_IN),
    .readData2IN(readData2IN), .DestinoIN(DestinoIN),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .PCSrc(PCSrc), .stall(stall), .bus_err(bus_err),
    .MemtoRegOUT(MemtoRegOUT), .RegWriteOUT(RegWriteOUT), .readDataOUT(readDataOUT),
    .ALU_OUT(ALU_OUT), .DestinoOUT(DestinoOUT)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    BranchIN = 0; zeroIN = 0; MemReadIN = 0; MemWriteIN = 0; MemtoRegIN = 0; RegWriteIN = 0;
    ALU_IN = '0; readData2IN = '0; DestinoIN = '0; dmem_rdata = '0; dmem_ack = 0;
  endtask

  // One instruction held at EX/MEM until it leaves the stage. delay = cycle index of the
  // ack (0 = same cycle), negative = memory never answers.
  task automatic do_instr(input int kind, input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [AW-1:0] dest, input logic rw, input logic zero,
                          input int delay, input logic stray_ack, input logic [DW-1:0] rd_ack);
    logic memop, misal, tmo, exp_rw, exp_stall;
    int   last;
    memop = (kind == K_LW) || (kind == K_SW);
    misal = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misal = memop && (addr[1:0] != 2'b00);
`endif
    exp_rw = (kind == K_LW) ? 1'b1 : (kind == K_ALU) ? rw : 1'b0;
    if (!memop || misal) begin
      last = 0;
      tmo  = misal;
    end else if (delay >= 0 && delay <= TO - 1) begin
      last = delay;
      tmo  = 1'b0;
    end else begin
      last = TO - 1;
      tmo  = 1'b1;
    end
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      BranchIN    = (kind == K_BR);
      zeroIN      = zero;
      MemReadIN   = (kind == K_LW);
      MemWriteIN  = (kind == K_SW);
      MemtoRegIN  = (kind == K_LW);
      RegWriteIN  = exp_rw;
      ALU_IN      = addr;
      readData2IN = wd;
      DestinoIN   = dest;
      dmem_ack    = (memop && !misal) ? (c == delay) : stray_ack;
      dmem_rdata  = (c == delay) ? rd_ack : DW'($urandom);
      #1;
      exp_stall = (c < last);
      check_eq("stall", stall, exp_stall);
      check_eq("PCSrc", PCSrc, (kind == K_BR) && zero && !exp_stall);
      check_eq("dmem_req", dmem_req, memop && !misal);
      if (memop && !misal) begin
        check_eq("dmem_addr", dmem_addr, addr);
        check_eq("dmem_wdata", dmem_wdata, wd);
        check_eq("dmem_we", dmem_we, kind == K_SW);
      end
      @(posedge clk);
      #1;
      if (c < last || tmo) begin
        check_eq("bubble_rw", RegWriteOUT, 1'b0);
        check_eq("bubble_m2r", MemtoRegOUT, 1'b0);
        check_eq("bus_err", bus_err, (c == last) && tmo);
      end else begin
        check_eq("wb_rw", RegWriteOUT, exp_rw);
        check_eq("wb_m2r", MemtoRegOUT, kind == K_LW);
        check_eq("wb_alu", ALU_OUT, addr);
        check_eq("wb_dest", DestinoOUT, dest);
        if (kind == K_LW) check_eq("wb_rdata", readDataOUT, rd_ack);
        check_eq("bus_err", bus_err, 1'b0);
      end
    end
  endtask

  initial begin
    int kind, dly, r;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req", dmem_req, 1'b0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_rw", RegWriteOUT, 1'b0);
    check_eq("rst_alu", ALU_OUT, 0);
    check_eq("rst_err", bus_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    do_instr(K_ALU, 32'h1234, 32'h0, 5'd7, 1'b1, 1'b0, 0, 1'b0, 32'h0);
    do_instr(K_LW, 32'h40, 32'h0, 5'd3, 1'b1, 1'b0, 0, 1'b0, 32'hDEADBEEF);
    do_instr(K_SW, 32'h80, 32'h55, 5'd0, 1'b0, 1'b0, 3, 1'b0, 32'h0);
    do_instr(K_LW, 32'h44, 32'h0, 5'd9, 1'b1, 1'b0, -1, 1'b0, 32'h0);
    do_instr(K_ALU, 32'h99, 32'h0, 5'd4, 1'b1, 1'b0, 0, 1'b1, 32'h0);
    do_instr(K_LW, 32'h48, 32'h0, 5'd5, 1'b1, 1'b0, TO - 1, 1'b0, 32'hA5A5A5A5);
    do_instr(K_BR, 32'h10, 32'h0, 5'd0, 1'b0, 1'b1, 0, 1'b0, 32'h0);
    do_instr(K_LW, 32'h42, 32'h0, 5'd6, 1'b1, 1'b0, 1, 1'b0, 32'h13579BDF);
    do_instr(K_ALU, 32'h77, 32'h0, 5'd2, 1'b1, 1'b0, 0, 1'b0, 32'h0);

    // Reset in the middle of an outstanding load.
    @(negedge clk);
    MemReadIN = 1; MemtoRegIN = 1; RegWriteIN = 1; ALU_IN = 32'h100; DestinoIN = 5'd11;
    dmem_ack = 0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("busy_stall", stall, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("arst_req", dmem_req, 1'b0);
    check_eq("arst_stall", stall, 1'b0);
    check_eq("arst_alu", ALU_OUT, 0);
    check_eq("arst_dest", DestinoOUT, 0);
    @(posedge clk);
    #1;
    check_eq("arst_req2", dmem_req, 1'b0);
    check_eq("arst_rw", RegWriteOUT, 1'b0);
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    do_instr(K_ALU, 32'hCAFE, 32'h0, 5'd1, 1'b1, 1'b0, 0, 1'b1, 32'h0);

    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(0, 3));
      r    = int'($urandom_range(0, 9));
      if (r < 6)      dly = int'($urandom_range(0, 4));
      else if (r < 8) dly = int'($urandom_range(5, TO - 1));
      else            dly = -1;
      do_instr(kind, DW'($urandom), DW'($urandom), AW'($urandom), 1'($urandom),
               1'($urandom), dly, 1'($urandom), DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
